wb_classic_to_pipelined: RTL

Converts the classic Wishbone master port driven by the AHB-to-Wishbone bridge into a pipelined Wishbone (B4, stall-aware) master port for the Controller memory interface. It sits between the bridge output and the Controller memory port, and replaces the ad-hoc PIPELINED_WISHBONE ack/data register in the top wrapper.
Each transfer is registered, so the downstream slave sees a clean single-beat STB. Responses are registered back to the bridge. A per-transfer timeout returns an error instead of hanging the core.

---
 rtl/wb_adapter_pkg.sv | 20 ++
 rtl/wb_timeout_ctr.sv | 43 ++++
 rtl/wb_classic_to_pipelined.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/wb_adapter_pkg.sv
// Shared types and sizing helpers for the classic-to-pipelined Wishbone adapter.
package wb_adapter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    RESP,
    ERR
  } state_e;

  function automatic int unsigned sel_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic int unsigned timeout_width(input int unsigned timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Per-transfer down-counter; expired is high in the cycle whose decrement reaches zero.
module wb_timeout_ctr
  import wb_adapter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec_en,
  output logic expired
);

  localparam int unsigned CW =
    (timeout_width(TIMEOUT_CYCLES) > 0) ? timeout_width(TIMEOUT_CYCLES) : 1;

  if (TIMEOUT_CYCLES == 0) begin : g_disabled
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst, load, dec_en};
    assign expired       = 1'b0;
  end else begin : g_enabled
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (load) begin
        cnt_d = CW'(TIMEOUT_CYCLES);
      end else if (dec_en && (cnt_q != '0)) begin
        cnt_d = cnt_q - CW'(1);
      end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end

    // Only consulted in REQ/WAIT, which always start from a fresh load.
    assign expired = (cnt_q == CW'(1));
  end

endmodule

// File: rtl/wb_classic_to_pipelined.sv
// Registers one classic Wishbone transfer onto a stall-aware pipelined port and
// returns a registered ack, or an error when the slave does not answer in time.
module wb_classic_to_pipelined
  import wb_adapter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             s_cyc,
  input  logic                             s_stb,
  input  logic                             s_we,
  input  logic [sel_width(DATA_WIDTH)-1:0] s_sel,
  input  logic [ADDR_WIDTH-1:0]            s_adr,
  input  logic [DATA_WIDTH-1:0]            s_dat_w,
  output logic [DATA_WIDTH-1:0]            s_dat_r,
  output logic                             s_ack,
  output logic                             s_err,
  output logic                             m_cyc,
  output logic                             m_stb,
  output logic                             m_we,
  output logic [sel_width(DATA_WIDTH)-1:0] m_sel,
  output logic [ADDR_WIDTH-1:0]            m_adr,
  output logic [DATA_WIDTH-1:0]            m_dat_w,
  input  logic [DATA_WIDTH-1:0]            m_dat_r,
  input  logic                             m_ack,
  input  logic                             m_stall
);

  localparam int unsigned SW = sel_width(DATA_WIDTH);

  state_e                state_q, state_d;
  logic                  m_cyc_q, m_cyc_d;
  logic                  m_stb_q, m_stb_d;
  logic                  m_we_q, m_we_d;
  logic [SW-1:0]         m_sel_q, m_sel_d;
  logic [ADDR_WIDTH-1:0] m_adr_q, m_adr_d;
  logic [DATA_WIDTH-1:0] m_dat_w_q, m_dat_w_d;
  logic [DATA_WIDTH-1:0] s_dat_r_q, s_dat_r_d;

  logic ctr_load, ctr_dec, expired;
  logic do_ack, do_err, do_abort;

  wb_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk    (clk),
    .rst    (rst),
    .load   (ctr_load),
    .dec_en (ctr_dec),
    .expired(expired)
  );

  always_comb begin
    // NOTE: every _d starts from its hold value so no branch can leave it unassigned (no latches).
    state_d   = state_q;
    m_cyc_d   = m_cyc_q;
    m_stb_d   = m_stb_q;
    m_we_d    = m_we_q;
    m_sel_d   = m_sel_q;
    m_adr_d   = m_adr_q;
    m_dat_w_d = m_dat_w_q;
    s_dat_r_d = s_dat_r_q;
    ctr_load  = 1'b0;
    ctr_dec   = 1'b0;
    do_ack    = 1'b0;
    do_err    = 1'b0;
    do_abort  = 1'b0;

    case (state_q)
      IDLE: begin
        if (s_cyc && s_stb) begin
          m_we_d    = s_we;
          m_sel_d   = s_sel;
          m_adr_d   = s_adr;
          m_dat_w_d = s_dat_w;
          m_cyc_d   = 1'b1;
          m_stb_d   = 1'b1;
          ctr_load  = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        ctr_dec = 1'b1;
        if (!s_cyc) begin
          do_abort = 1'b1;
        end else if (!m_stall && m_ack) begin
          do_ack = 1'b1;
        end else if (expired) begin
          do_err = 1'b1;
        end else if (!m_stall) begin
          m_stb_d = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        ctr_dec = 1'b1;
        if (!s_cyc)        do_abort = 1'b1;
        else if (m_ack)    do_ack   = 1'b1;
        else if (expired)  do_err   = 1'b1;
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Any way out of REQ/WAIT ends the bus cycle; the flags are mutually exclusive.
    if (do_abort || do_ack || do_err) begin
      m_cyc_d = 1'b0;
      m_stb_d = 1'b0;
    end
    if (do_abort) state_d = IDLE;
    if (do_ack) begin
      state_d   = RESP;
      s_dat_r_d = m_we_q ? '0 : m_dat_r;
    end
    if (do_err) begin
      state_d   = ERR;
      s_dat_r_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      m_cyc_q   <= 1'b0;
      m_stb_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_sel_q   <= '0;
      m_adr_q   <= '0;
      m_dat_w_q <= '0;
      s_dat_r_q <= '0;
    end else begin
      state_q   <= state_d;
      m_cyc_q   <= m_cyc_d;
      m_stb_q   <= m_stb_d;
      m_we_q    <= m_we_d;
      m_sel_q   <= m_sel_d;
      m_adr_q   <= m_adr_d;
      m_dat_w_q <= m_dat_w_d;
      s_dat_r_q <= s_dat_r_d;
    end
  end

  assign s_ack   = (state_q == RESP);
  assign s_err   = (state_q == ERR);
  assign s_dat_r = s_dat_r_q;
  assign m_cyc   = m_cyc_q;
  assign m_stb   = m_stb_q;
  assign m_we    = m_we_q;
  assign m_sel   = m_sel_q;
  assign m_adr   = m_adr_q;
  assign m_dat_w = m_dat_w_q;

endmodule
